// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the register-access initiator.
// Status codes, access direction and byte-strobe to bit-mask expansion.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_OKAY   = 2'b00,
      RGGEN_EXOKAY = 2'b01,
      RGGEN_SLVERR = 2'b10,
      RGGEN_DECERR = 2'b11
   } rggen_status;

   typedef enum logic {
      RGGEN_READ  = 1'b0,
      RGGEN_WRITE = 1'b1
   } rggen_access;

   localparam int RGGEN_MAX_STROBES = 8;

   function automatic logic [63:0] rggen_expand_strobe(
      input logic [RGGEN_MAX_STROBES-1:0] strobe
   );
      logic [63:0] mask;
      mask = '0;
      for (int i = 0; i < RGGEN_MAX_STROBES; i++) begin
         mask[8*i+:8] = {8{strobe[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/rggen_access_timeout_counter.sv
// Responder wait counter; o_expired flags that the count hit i_limit.
// Only built when RGGEN_REGISTER_ACCESS_TIMEOUT_EN is defined.
module rggen_access_timeout_counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_limit,
   output logic             o_expired
);

   logic [WIDTH-1:0] count_q;

   assign o_expired = (count_q == i_limit);

   // Count enabled cycles; saturate at the limit so it never wraps.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         count_q <= '0;
      end else if (i_enable && !o_expired) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/rggen_register_access_initiator.sv
// Host request -> single register access -> host response.
// Optional responder timeout: RGGEN_REGISTER_ACCESS_TIMEOUT_EN.
module rggen_register_access_initiator
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_write,
   input  logic [ADDRESS_WIDTH-1:0] i_req_address,
   input  logic [DATA_WIDTH-1:0]   i_req_write_data,
   input  logic [DATA_WIDTH/8-1:0] i_req_strobe,
   output logic                    o_reg_valid,
   output logic                    o_reg_write,
   output logic [ADDRESS_WIDTH-1:0] o_reg_address,
   output logic [DATA_WIDTH-1:0]   o_reg_write_data,
   output logic [DATA_WIDTH-1:0]   o_reg_write_mask,
   input  logic                    i_reg_ready,
   input  logic [1:0]              i_reg_status,
   input  logic [DATA_WIDTH-1:0]   i_reg_read_data,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [1:0]              o_rsp_status,
   output logic [DATA_WIDTH-1:0]   o_rsp_read_data
);

   localparam int ALIGN_BITS = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
      ~((ADDRESS_WIDTH'(1) << ALIGN_BITS) - ADDRESS_WIDTH'(1));

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESPONSE
   } state_e;

   state_e                   state_q;
   logic                     req_ready_q;
   logic                     reg_valid_q;
   logic                     rsp_valid_q;
   rggen_access              access_q;
   logic [ADDRESS_WIDTH-1:0] address_q;
   logic [DATA_WIDTH-1:0]    write_data_q;
   logic [DATA_WIDTH-1:0]    write_mask_q;
   logic [DATA_WIDTH-1:0]    read_data_q;
   rggen_status              status_q;
   logic                     timeout_expired;

`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
   rggen_access_timeout_counter #(
      .WIDTH (16)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   ((state_q == IDLE) && i_req_valid),
      .i_enable  ((state_q == ACCESS) && !i_reg_ready),
      .i_limit   (16'(TIMEOUT_CYCLES - 1)),
      .o_expired (timeout_expired)
   );
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_expired = 1'b0;
`endif

   // Transaction FSM with all host/responder-facing outputs registered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         reg_valid_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         access_q     <= RGGEN_READ;
         address_q    <= '0;
         write_data_q <= '0;
         write_mask_q <= '0;
         read_data_q  <= '0;
         status_q     <= RGGEN_OKAY;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_req_valid) begin
                  state_q      <= ACCESS;
                  req_ready_q  <= 1'b0;
                  reg_valid_q  <= 1'b1;
                  access_q     <= i_req_write ? RGGEN_WRITE : RGGEN_READ;
                  address_q    <= i_req_address & ADDR_MASK;
                  write_data_q <= i_req_write_data;
                  write_mask_q <= DATA_WIDTH'(
                     rggen_expand_strobe(8'(i_req_strobe)));
               end
            end
            ACCESS: begin
               if (i_reg_ready) begin
                  state_q     <= RESPONSE;
                  reg_valid_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  status_q    <= rggen_status'(i_reg_status);
                  read_data_q <= (access_q == RGGEN_WRITE) ?
                                 '0 : i_reg_read_data;
               end else if (timeout_expired) begin
                  state_q     <= RESPONSE;
                  reg_valid_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  status_q    <= RGGEN_SLVERR;
                  read_data_q <= '0;
               end
            end
            RESPONSE: begin
               if (i_rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_req_ready      = req_ready_q;
   assign o_reg_valid      = reg_valid_q;
   assign o_reg_write      = (access_q == RGGEN_WRITE);
   assign o_reg_address    = address_q;
   assign o_reg_write_data = write_data_q;
   assign o_reg_write_mask = write_mask_q;
   assign o_rsp_valid      = rsp_valid_q;
   assign o_rsp_status     = status_q;
   assign o_rsp_read_data  = read_data_q;

endmodule

// File: tb/tb_rggen_register_access_initiator.sv
// Directed bench for rggen_register_access_initiator.
// Timeout scenario runs when RGGEN_REGISTER_ACCESS_TIMEOUT_EN is defined.
module tb_rggen_register_access_initiator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_address = '0;
   logic [31:0] req_write_data = '0;
   logic [3:0]  req_strobe = '0;
   logic        reg_valid;
   logic        reg_write;
   logic [15:0] reg_address;
   logic [31:0] reg_write_data;
   logic [31:0] reg_write_mask;
   logic        reg_ready = 1'b0;
   logic [1:0]  reg_status = '0;
   logic [31:0] reg_read_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_status;
   logic [31:0] rsp_read_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rggen_register_access_initiator #(
      .ADDRESS_WIDTH  (16),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_write      (req_write),
      .i_req_address    (req_address),
      .i_req_write_data (req_write_data),
      .i_req_strobe     (req_strobe),
      .o_reg_valid      (reg_valid),
      .o_reg_write      (reg_write),
      .o_reg_address    (reg_address),
      .o_reg_write_data (reg_write_data),
      .o_reg_write_mask (reg_write_mask),
      .i_reg_ready      (reg_ready),
      .i_reg_status     (reg_status),
      .i_reg_read_data  (reg_read_data),
      .o_rsp_valid      (rsp_valid),
      .i_rsp_ready      (rsp_ready),
      .o_rsp_status     (rsp_status),
      .o_rsp_read_data  (rsp_read_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic w, input logic [15:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      req_valid      = 1'b1;
      req_write      = w;
      req_address    = a;
      req_write_data = d;
      req_strobe     = s;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++;
         $display("FAIL reset_req_ready got %b want 1", req_ready); end
      checks++; if (reg_valid !== 1'b0) begin errors++;
         $display("FAIL reset_reg_valid got %b want 0", reg_valid); end
      checks++; if ({reg_write, reg_address, reg_write_data, reg_write_mask} !== 81'd0) begin errors++;
         $display("FAIL reset_reg_payload got %b %h %h %h want all 0",
                  reg_write, reg_address, reg_write_data, reg_write_mask); end
      checks++; if ({rsp_valid, rsp_status, rsp_read_data} !== 35'd0) begin errors++;
         $display("FAIL reset_rsp got %b %b %h want 0 00 0", rsp_valid, rsp_status, rsp_read_data); end
   endtask

   task automatic test_write();
      drive_req(1'b1, 16'h0013, 32'hA5A5_1234, 4'b0101);
      tick();
      req_valid = 1'b0;
      checks++; if (reg_valid !== 1'b1 || req_ready !== 1'b0) begin errors++;
         $display("FAIL wr_reg_valid got valid=%b ready=%b want 1 0", reg_valid, req_ready); end
      checks++; if (reg_address !== 16'h0010) begin errors++;
         $display("FAIL wr_address got %h want 0010", reg_address); end
      checks++; if (reg_write_mask !== 32'h00FF_00FF) begin errors++;
         $display("FAIL wr_mask got %h want 00ff00ff", reg_write_mask); end
      checks++; if (reg_write !== 1'b1 || reg_write_data !== 32'hA5A5_1234) begin errors++;
         $display("FAIL wr_data got w=%b %h want 1 a5a51234", reg_write, reg_write_data); end
      reg_read_data = 32'h1111_2222;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (reg_valid !== 1'b1 || rsp_valid !== 1'b0 || reg_address !== 16'h0010) begin
            errors++; $display("FAIL wr_wait got valid=%b rsp=%b addr=%h want 1 0 0010",
                               reg_valid, rsp_valid, reg_address); end
      end
      reg_ready  = 1'b1;
      reg_status = 2'b00;
      tick();
      reg_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || reg_valid !== 1'b0) begin errors++;
         $display("FAIL wr_rsp_valid got rsp=%b reg=%b want 1 0", rsp_valid, reg_valid); end
      checks++; if (rsp_status !== 2'b00 || rsp_read_data !== 32'h0) begin errors++;
         $display("FAIL wr_rsp_data got %b %h want 00 0", rsp_status, rsp_read_data); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
         $display("FAIL wr_done got rsp=%b ready=%b want 0 1", rsp_valid, req_ready); end
   endtask

   task automatic test_read_backpressure_decerr();
      drive_req(1'b0, 16'h0004, 32'h0, 4'hF);
      reg_ready     = 1'b1;
      reg_status    = 2'b00;
      reg_read_data = 32'hDEAD_BEEF;
      tick();
      req_valid = 1'b0;
      checks++; if (reg_valid !== 1'b1 || reg_write !== 1'b0 || req_ready !== 1'b0) begin errors++;
         $display("FAIL rd_access got v=%b w=%b rdy=%b want 1 0 0", reg_valid, reg_write, req_ready); end
      checks++; if (reg_address !== 16'h0004 || reg_write_mask !== 32'hFFFF_FFFF) begin errors++;
         $display("FAIL rd_payload got %h %h want 0004 ffffffff", reg_address, reg_write_mask); end
      tick();
      reg_ready     = 1'b0;
      reg_read_data = 32'h0;
      checks++; if (rsp_valid !== 1'b1 || rsp_read_data !== 32'hDEAD_BEEF || rsp_status !== 2'b00) begin
         errors++; $display("FAIL rd_rsp got v=%b %b %h want 1 00 deadbeef",
                            rsp_valid, rsp_status, rsp_read_data); end
      drive_req(1'b1, 16'h0022, 32'h7777_8888, 4'b1000);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (rsp_valid !== 1'b1 || rsp_read_data !== 32'hDEAD_BEEF ||
                       rsp_status !== 2'b00 || req_ready !== 1'b0 || reg_valid !== 1'b0) begin
            errors++; $display("FAIL bp_hold got v=%b %b %h rdy=%b reg=%b want 1 00 deadbeef 0 0",
                               rsp_valid, rsp_status, rsp_read_data, req_ready, reg_valid); end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || reg_valid !== 1'b0) begin errors++;
         $display("FAIL bp_release got v=%b rdy=%b reg=%b want 0 1 0", rsp_valid, req_ready, reg_valid); end
      tick();
      req_valid = 1'b0;
      checks++; if (reg_valid !== 1'b1 || reg_address !== 16'h0020 ||
                    reg_write_mask !== 32'hFF00_0000) begin errors++;
         $display("FAIL dec_access got v=%b %h %h want 1 0020 ff000000",
                  reg_valid, reg_address, reg_write_mask); end
      reg_ready     = 1'b1;
      reg_status    = 2'b11;
      reg_read_data = 32'hCAFE_0000;
      tick();
      reg_ready  = 1'b0;
      reg_status = 2'b00;
      checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b11 || rsp_read_data !== 32'h0) begin
         errors++; $display("FAIL dec_rsp got v=%b %b %h want 1 11 0",
                            rsp_valid, rsp_status, rsp_read_data); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_zero_strobe_read();
      drive_req(1'b0, 16'h000B, 32'hFFFF_FFFF, 4'b0000);
      tick();
      req_valid = 1'b0;
      checks++; if (reg_valid !== 1'b1 || reg_write_mask !== 32'h0 || reg_address !== 16'h0008) begin
         errors++; $display("FAIL zs_access got v=%b %h %h want 1 0 0008",
                            reg_valid, reg_write_mask, reg_address); end
      reg_ready     = 1'b1;
      reg_read_data = 32'h0BAD_F00D;
      tick();
      reg_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_read_data !== 32'h0BAD_F00D) begin errors++;
         $display("FAIL zs_rsp got v=%b %h want 1 0badf00d", rsp_valid, rsp_read_data); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      drive_req(1'b1, 16'h0030, 32'h1234_5678, 4'hF);
      tick();
      req_valid = 1'b0;
      checks++; if (reg_valid !== 1'b1) begin errors++;
         $display("FAIL mr_pre got %b want 1", reg_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (reg_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
                    reg_address !== 16'h0) begin errors++;
         $display("FAIL mr_after got reg=%b rsp=%b rdy=%b addr=%h want 0 0 1 0000",
                  reg_valid, rsp_valid, req_ready, reg_address); end
      reg_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (rsp_valid !== 1'b0 || reg_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL mr_dropped got rsp=%b reg=%b rdy=%b want 0 0 1",
                     rsp_valid, reg_valid, req_ready); end
      end
      reg_ready = 1'b0;
   endtask

`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
   task automatic test_timeout();
      drive_req(1'b0, 16'h0040, 32'h0, 4'hF);
      reg_read_data = 32'h5A5A_5A5A;
      tick();
      req_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (rsp_valid !== 1'b0 || reg_valid !== 1'b1) begin errors++;
            $display("FAIL to_wait%0d got rsp=%b reg=%b want 0 1", i, rsp_valid, reg_valid); end
      end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_read_data !== 32'h0) begin
         errors++; $display("FAIL to_expire got v=%b %b %h want 1 10 0",
                            rsp_valid, rsp_status, rsp_read_data); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      drive_req(1'b0, 16'h0044, 32'h0, 4'hF);
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      reg_ready     = 1'b1;
      reg_status    = 2'b00;
      reg_read_data = 32'h0000_0055;
      tick();
      reg_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_read_data !== 32'h55) begin
         errors++; $display("FAIL to_ready_wins got v=%b %b %h want 1 00 00000055",
                            rsp_valid, rsp_status, rsp_read_data); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask
`else
   task automatic test_no_timeout();
      drive_req(1'b0, 16'h0040, 32'h0, 4'hF);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      checks++; if (reg_valid !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
         $display("FAIL nt_wait got reg=%b rsp=%b want 1 0", reg_valid, rsp_valid); end
      reg_ready     = 1'b1;
      reg_read_data = 32'h0000_0077;
      tick();
      reg_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_read_data !== 32'h77) begin errors++;
         $display("FAIL nt_rsp got v=%b %h want 1 00000077", rsp_valid, rsp_read_data); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      tick();
      test_reset();
      test_write();
      test_read_backpressure_decerr();
      test_zero_strobe_read();
      test_reset_mid_access();
`ifdef RGGEN_REGISTER_ACCESS_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rggen_register_access_initiator.md
Name: rggen_register_access_initiator

Overview:
- Initiator end of the register-access protocol that bit-field responders consume.
- Accepts one host request per transaction over a valid/ready handshake, then drives a single register access:
  - valid, write, address, write data, and a bit-level write mask expanded from byte strobes.
- Waits for the responder's ready, then returns read data and status on a response valid/ready handshake.
- Sits between a bus protocol bridge and the register block's address decoder.

Parameters:
- ADDRESS_WIDTH, 16, register address width in bits (byte address).
- DATA_WIDTH, 32, data width in bits; legal values 8/16/32/64.
- TIMEOUT_CYCLES, 256, responder wait limit; used only with the optional feature; legal range 2..65535.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; one clock; reset is synchronous and active-high.
- i_req_valid  input  1  host request valid.
- o_req_ready  output  1  host request accepted.
- i_req_write  input  1  1=write, 0=read.
- i_req_address  input  ADDRESS_WIDTH  byte address.
- i_req_write_data  input  DATA_WIDTH  write data.
- i_req_strobe  input  DATA_WIDTH/8  byte strobes.
- o_reg_valid  output  1  register access valid.
- o_reg_write  output  1  access direction.
- o_reg_address  output  ADDRESS_WIDTH  word-aligned address (low log2(DATA_WIDTH/8) bits forced 0).
- o_reg_write_data  output  DATA_WIDTH  write data.
- o_reg_write_mask  output  DATA_WIDTH  bit mask; each strobe bit is replicated over its 8 data bits.
- i_reg_ready  input  1  responder completes access.
- i_reg_status  input  2  responder status (OKAY/EXOKAY/SLVERR/DECERR).
- i_reg_read_data  input  DATA_WIDTH  responder read data.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  host accepts response.
- o_rsp_status  output  2  returned status.
- o_rsp_read_data  output  DATA_WIDTH  returned read data; 0 for writes.

Behaviour:
- FSM states:
  - IDLE -> ACCESS on i_req_valid.
  - ACCESS -> RESPONSE on i_reg_ready.
  - RESPONSE -> IDLE on i_rsp_ready.
- o_req_ready = 1 only in IDLE. A request is accepted on the cycle where valid & ready; all request fields are registered then.
- o_reg_valid = 1 exactly in ACCESS.
  - Rises the cycle after acceptance.
  - Payload stays stable until i_reg_ready is sampled high.
- On i_reg_ready, the cycle captures i_reg_status and, for reads, i_reg_read_data. For writes, rsp read data is captured as 0.
- o_rsp_valid = 1 exactly in RESPONSE.
  - Rises the cycle after i_reg_ready.
  - Held with stable data until i_rsp_ready.
- Minimum latency: acceptance -> rsp_valid = 2 cycles.
- Throughput: no new request is accepted until the response handshake completes. i_rsp_ready asserted in RESPONSE returns to IDLE. Next accept is no earlier than the following cycle, so max one transaction per 3 cycles.
- i_reg_ready outside ACCESS is ignored.
- A read with all strobes 0 is still issued, with o_reg_write_mask = 0.
- Reset (any state, including mid-access):
  - FSM returns to IDLE; any in-flight transaction is dropped with no response.
  - Reset values: o_req_ready=1 after reset deasserts (0 while i_rst=1 is not required; it is 1 from the first post-reset cycle).
  - o_reg_valid=0, o_reg_write=0, o_reg_address=0, o_reg_write_data=0, o_reg_write_mask=0.
  - o_rsp_valid=0, o_rsp_status=OKAY, o_rsp_read_data=0.
- Status encoding: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.

Optional Feature:
- Macro: RGGEN_REGISTER_ACCESS_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without i_reg_ready.
  - When the count reaches TIMEOUT_CYCLES-1 with ready still low, the FSM goes to RESPONSE with status SLVERR and read data 0.
  - i_reg_ready on that same cycle takes priority: normal completion.
- When undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package rggen_rtl_pkg:
  - rggen_status enum (four codes above).
  - rggen_access enum (READ/WRITE).
  - Function that expands strobes to a bit mask.
- One natural sub-module: rggen_access_timeout_counter (enable, clear, limit, expired output), instantiated only under the macro.

Test Plan:
- Reset then write: addr 0x0013, data 0xA5A5_1234, strobe 4'b0101 -> o_reg_address 0x0010, mask 0x00FF_00FF, reg_valid the cycle after accept. Responder ready after 3 cycles with OKAY -> rsp_valid next cycle, status 0, read data 0.
- Read: addr 0x0004, strobe 4'hF; responder returns 0xDEAD_BEEF with ready on the first ACCESS cycle -> rsp_valid 2 cycles after accept with 0xDEAD_BEEF; req_ready low throughout.
- Response backpressure: hold i_rsp_ready=0 for 5 cycles -> rsp_valid/status/data stable for those 5 cycles; next request accepted only after the handshake.
- DECERR passthrough: responder returns status 2'b11 on a write -> o_rsp_status 2'b11.
- Reset mid-ACCESS: i_rst=1 for 1 cycle while reg_valid=1 -> next cycle reg_valid=0, rsp_valid=0, req_ready=1; no response ever appears for the dropped request.
- With macro, TIMEOUT_CYCLES=4, responder never ready -> rsp_valid 4 cycles after reg_valid rise, status SLVERR, data 0. Repeat with ready on the 4th ACCESS cycle -> OKAY.
